// File: rtl/audio_in_level_detector_if.sv
// Sample handshake between the audio controller (master) and the level detector (slave).
interface audio_in_level_detector_if;
  logic        audio_in_available;
  logic [31:0] left_channel_audio_in;
  logic [31:0] right_channel_audio_in;
  logic        read_audio_in;

  modport master (
    output audio_in_available,
    output left_channel_audio_in,
    output right_channel_audio_in,
    input  read_audio_in
  );

  modport slave (
    input  audio_in_available,
    input  left_channel_audio_in,
    input  right_channel_audio_in,
    output read_audio_in
  );
endinterface

// File: rtl/audio_in_level_detector.sv
// Windowed peak-magnitude detector for stereo audio samples, with a held
// sound_detected flag and one-cycle strobes for detection and window completion.
module audio_in_level_detector #(
  parameter int WINDOW_LOG2 = 10,
  parameter int HOLD_CYCLES = 2500000
) (
  input  logic                       CLOCK_50,
  input  logic                       reset,
  input  logic                       enable,
  audio_in_level_detector_if.slave   audio,
  input  logic [30:0]                threshold,
  output logic [30:0]                peak_level,
  output logic                       sound_detected,
  output logic                       detect_pulse,
  output logic                       window_done
);

  typedef enum logic [1:0] {IDLE, READ, CALC, UPDATE} state_t;

  localparam logic [23:0] HOLD_LOAD = 24'(HOLD_CYCLES);
  localparam logic [WINDOW_LOG2-1:0] COUNT_ONE = WINDOW_LOG2'(1);

  state_t                  state_reg;
  state_t                  state_next;
  logic signed [31:0]      left_reg;
  logic signed [31:0]      right_reg;
  logic signed [31:0]      mono;
  logic [30:0]             mag;
  logic [30:0]             mag_reg;
  logic [30:0]             run_peak_reg;
  logic [30:0]             peak_candidate;
  logic [WINDOW_LOG2-1:0]  count_reg;
  logic                    wrap;
  logic [30:0]             peak_level_reg;
  logic                    window_done_reg;
  logic [23:0]             hold_reg;
  logic [23:0]             hold_next;
  logic                    qualify;
  logic                    sound_reg;
  logic                    sound_next;
  logic                    pulse_reg;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // enable is only consulted in IDLE, so a sample already popped always finishes.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (enable && audio.audio_in_available) state_next = READ;
      READ:    state_next = CALC;
      CALC:    state_next = UPDATE;
      UPDATE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Gated by reset so the pop request is low throughout reset, not just after the first edge.
  assign audio.read_audio_in = (state_reg == READ) && !reset;

  assign mono = (left_reg >>> 1) + (right_reg >>> 1);

  // The low 31 bits of -mono equal |mono| except at -2^31, which saturates.
  always_comb begin
    mag = mono[30:0];
    if (mono[31]) begin
      if (mono[30:0] == 31'd0) begin
        mag = 31'h7FFF_FFFF;
      end else begin
        mag = ~mono[30:0] + 31'd1;
      end
    end
  end

  assign peak_candidate = (mag_reg > run_peak_reg) ? mag_reg : run_peak_reg;
  assign wrap           = (count_reg == {WINDOW_LOG2{1'b1}});

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      left_reg        <= '0;
      right_reg       <= '0;
      mag_reg         <= '0;
      run_peak_reg    <= '0;
      count_reg       <= '0;
      peak_level_reg  <= '0;
      window_done_reg <= 1'b0;
    end else begin
      window_done_reg <= 1'b0;
      if (state_reg == READ) begin
        left_reg  <= audio.left_channel_audio_in;
        right_reg <= audio.right_channel_audio_in;
      end
      if (state_reg == CALC) begin
        mag_reg <= mag;
      end
      if (state_reg == UPDATE) begin
        count_reg <= count_reg + COUNT_ONE;
        if (wrap) begin
          peak_level_reg  <= peak_candidate;
          run_peak_reg    <= '0;
          window_done_reg <= 1'b1;
        end else begin
          run_peak_reg <= peak_candidate;
        end
      end
    end
  end

  // window_done coincides with the first cycle peak_level shows the new window.
  assign qualify = window_done_reg && (peak_level_reg >= threshold);

  always_comb begin
    hold_next = hold_reg;
    if (qualify) begin
      hold_next = HOLD_LOAD;
    end else if (hold_reg != 24'd0) begin
      hold_next = hold_reg - 24'd1;
    end
  end

  assign sound_next = (hold_next != 24'd0);

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      hold_reg  <= '0;
      sound_reg <= 1'b0;
      pulse_reg <= 1'b0;
    end else begin
      hold_reg  <= hold_next;
      sound_reg <= sound_next;
      pulse_reg <= sound_next && !sound_reg;
    end
  end

  assign peak_level     = peak_level_reg;
  assign window_done    = window_done_reg;
  assign sound_detected = sound_reg;
  assign detect_pulse   = pulse_reg;

endmodule

// File: tb/tb_audio_in_level_detector.sv
// Directed bench for audio_in_level_detector: 4-sample windows, 20-cycle hold.
module tb_audio_in_level_detector;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [30:0] threshold;
  logic [30:0] peak_level;
  logic        sound_detected;
  logic        detect_pulse;
  logic        window_done;

  int checks = 0;
  int errors = 0;

  int sd_cycles = 0;
  int pulse_cnt = 0;
  int read_cnt  = 0;

  audio_in_level_detector_if aif();

  audio_in_level_detector #(
    .WINDOW_LOG2(2),
    .HOLD_CYCLES(20)
  ) dut (
    .CLOCK_50      (clk),
    .reset         (reset),
    .enable        (enable),
    .audio         (aif.slave),
    .threshold     (threshold),
    .peak_level    (peak_level),
    .sound_detected(sound_detected),
    .detect_pulse  (detect_pulse),
    .window_done   (window_done)
  );

  always #5 clk = ~clk;

  // Per-cycle activity counters; sampled before the DUT's registers update.
  always @(posedge clk) begin
    if (sound_detected)    sd_cycles = sd_cycles + 1;
    if (detect_pulse)      pulse_cnt = pulse_cnt + 1;
    if (aif.read_audio_in) read_cnt  = read_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
    $display("check %-16s observed %0h expected %0h", tag, obs, exp);
  endtask

  // Called at a negedge while the FSM idles; returns at the negedge of the
  // following IDLE cycle, where window_done/peak_level of this sample are visible.
  task automatic feed(input logic [31:0] l, input logic [31:0] r, input bit drop_en);
    bit got;
    got = 1'b0;
    aif.left_channel_audio_in  = l;
    aif.right_channel_audio_in = r;
    aif.audio_in_available     = 1'b1;
    for (int i = 0; i < 12 && !got; i++) begin
      @(negedge clk);
      if (aif.read_audio_in) got = 1'b1;
    end
    chk("pop_seen", 32'(got), 32'd1);
    aif.audio_in_available = 1'b0;
    if (drop_en) enable = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic feed_window(input logic [31:0] first);
    feed(first, first, 1'b0);
    feed(32'd0, 32'd0, 1'b0);
    feed(32'd0, 32'd0, 1'b0);
    feed(32'd0, 32'd0, 1'b0);
  endtask

  initial begin
    int vec[4];
    int idx, reads, last_c, first_c, gap_bad;
    int sd0, pl0, rd0;
    bit wd_seen;

    vec = '{1000, 2000, -3000, 200};
    reset = 1'b1;
    enable = 1'b1;
    threshold = 31'd5000;
    aif.audio_in_available = 1'b1;
    aif.left_channel_audio_in  = 32'(vec[0]);
    aif.right_channel_audio_in = 32'(vec[0]);
    repeat (3) @(negedge clk);
    chk("rst_read", 32'(aif.read_audio_in), 32'd0);
    chk("rst_peak", 32'(peak_level), 32'd0);
    chk("rst_sd", 32'(sound_detected), 32'd0);
    chk("rst_pulse", 32'(detect_pulse), 32'd0);
    chk("rst_wd", 32'(window_done), 32'd0);
    reset = 1'b0;
    chk("deassert_read", 32'(aif.read_audio_in), 32'd0);

    // Stream with available held high: pop cadence and first window.
    idx = 0; reads = 0; last_c = -10; first_c = -1; gap_bad = 0; wd_seen = 1'b0;
    for (int c = 0; c < 40 && !wd_seen; c++) begin
      @(negedge clk);
      if (window_done) begin
        wd_seen = 1'b1;
        aif.audio_in_available = 1'b0;
        chk("w1_peak", 32'(peak_level), 32'd3000);
        chk("w1_reads", 32'(reads), 32'd4);
      end
      if (aif.read_audio_in) begin
        if (reads == 0) first_c = c;
        else if (c - last_c != 4) gap_bad++;
        reads++;
        last_c = c;
      end else if (c == last_c + 1 && idx < 3) begin
        idx++;
        aif.left_channel_audio_in  = 32'(vec[idx]);
        aif.right_channel_audio_in = 32'(vec[idx]);
      end
    end
    chk("w1_done", 32'(wd_seen), 32'd1);
    chk("first_pop_cycle", 32'(first_c), 32'd0);
    chk("pop_gap", 32'(gap_bad), 32'd0);
    chk("w1_no_sd", 32'(sound_detected), 32'd0);
    @(negedge clk);
    chk("wd_one_cycle", 32'(window_done), 32'd0);
    chk("peak_held", 32'(peak_level), 32'd3000);

    // Rounding and saturation corners.
    threshold = 31'h7FFF_FFFF;
    feed(32'h8000_0000, 32'h7FFF_FFFF, 1'b0);
    feed(32'd0, 32'd0, 1'b0);
    feed(32'd0, 32'd0, 1'b0);
    chk("w2_not_done", 32'(window_done), 32'd0);
    feed(32'd0, 32'd0, 1'b0);
    chk("w2_done", 32'(window_done), 32'd1);
    chk("mag_minus1", 32'(peak_level), 32'd1);
    pl0 = pulse_cnt;
    feed_window(32'h8000_0000);
    chk("mag_sat", 32'(peak_level), 32'h7FFF_FFFF);
    repeat (25) @(negedge clk);
    chk("sat_qualifies", 32'(pulse_cnt - pl0), 32'd1);

    // Single qualifying window: exactly HOLD_CYCLES of sound_detected.
    threshold = 31'd500;
    sd0 = sd_cycles; pl0 = pulse_cnt;
    feed_window(32'd600);
    chk("h1_done", 32'(window_done), 32'd1);
    chk("h1_peak", 32'(peak_level), 32'd600);
    chk("h1_sd_before", 32'(sound_detected), 32'd0);
    @(negedge clk);
    chk("h1_sd", 32'(sound_detected), 32'd1);
    chk("h1_pulse", 32'(detect_pulse), 32'd1);
    repeat (25) @(negedge clk);
    chk("h1_sd_cycles", 32'(sd_cycles - sd0), 32'd20);
    chk("h1_pulses", 32'(pulse_cnt - pl0), 32'd1);
    chk("h1_sd_off", 32'(sound_detected), 32'd0);

    // Back-to-back qualifying windows 16 cycles apart retrigger the hold.
    sd0 = sd_cycles; pl0 = pulse_cnt;
    feed_window(32'd600);
    feed_window(32'd600);
    repeat (30) @(negedge clk);
    chk("retrig_sd_cycles", 32'(sd_cycles - sd0), 32'd36);
    chk("retrig_pulses", 32'(pulse_cnt - pl0), 32'd1);

    // Below threshold: window still completes, no detection.
    threshold = 31'd700;
    sd0 = sd_cycles; pl0 = pulse_cnt;
    feed_window(32'd600);
    chk("low_done", 32'(window_done), 32'd1);
    chk("low_peak", 32'(peak_level), 32'd600);
    repeat (25) @(negedge clk);
    chk("low_sd_cycles", 32'(sd_cycles - sd0), 32'd0);
    chk("low_pulses", 32'(pulse_cnt - pl0), 32'd0);

    // Zero threshold: a silent window still qualifies.
    threshold = 31'd0;
    feed_window(32'd0);
    chk("zero_peak", 32'(peak_level), 32'd0);
    chk("zero_done", 32'(window_done), 32'd1);
    @(negedge clk);
    chk("zero_sd", 32'(sound_detected), 32'd1);
    repeat (25) @(negedge clk);

    // Reset while a sample is in CALC.
    threshold = 31'd500;
    feed_window(32'd600);
    @(negedge clk);
    chk("pre_rst_sd", 32'(sound_detected), 32'd1);
    aif.left_channel_audio_in  = 32'd5000;
    aif.right_channel_audio_in = 32'd5000;
    aif.audio_in_available = 1'b1;
    @(negedge clk);
    chk("rst_in_read", 32'(aif.read_audio_in), 32'd1);
    aif.audio_in_available = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("calc_rst_read", 32'(aif.read_audio_in), 32'd0);
    chk("calc_rst_peak", 32'(peak_level), 32'd0);
    chk("calc_rst_sd", 32'(sound_detected), 32'd0);
    chk("calc_rst_pulse", 32'(detect_pulse), 32'd0);
    chk("calc_rst_wd", 32'(window_done), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_idle", 32'(aif.read_audio_in), 32'd0);
    feed(32'd100, 32'd100, 1'b0);
    feed(32'd200, 32'd200, 1'b0);
    feed(32'd300, 32'd300, 1'b0);
    chk("discard_not_done", 32'(window_done), 32'd0);
    feed(32'd50, 32'd50, 1'b0);
    chk("discard_done", 32'(window_done), 32'd1);
    chk("discard_peak", 32'(peak_level), 32'd300);

    // Pause: enable falls during the second sample's READ cycle.
    threshold = 31'h7FFF_FFFF;
    feed(32'd300, 32'd300, 1'b0);
    feed(32'd900, 32'd900, 1'b1);
    aif.left_channel_audio_in  = 32'd7000;
    aif.right_channel_audio_in = 32'd7000;
    aif.audio_in_available = 1'b1;
    rd0 = read_cnt;
    repeat (50) @(negedge clk);
    chk("pause_pops", 32'(read_cnt - rd0), 32'd0);
    chk("pause_no_wd", 32'(window_done), 32'd0);
    aif.audio_in_available = 1'b0;
    enable = 1'b1;
    feed(32'd100, 32'd100, 1'b0);
    chk("resume_not_done", 32'(window_done), 32'd0);
    feed(32'hFFFF_FF38, 32'hFFFF_FF38, 1'b0);
    chk("resume_done", 32'(window_done), 32'd1);
    chk("resume_peak", 32'(peak_level), 32'd900);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
